// File: rtl/fir_stream_sink.sv
// ---------------------------------------------------------------------------
// fir_stream_sink
//
// Sample sink at the tail of a FIR datapath. Upstream presents one sample per
// enabled cycle, qualified by r_in, with no backpressure. Samples are held in
// a circular buffer until the host pulls them out with rd_en. When a sample
// arrives at a full buffer and no read frees a slot in that cycle, the sample
// is dropped and a sticky overflow flag is raised.
//
// Parameters
//   N      sample width in bits
//   DEPTH  buffer depth in samples (power of two, >= 2)
//
// Ports
//   clk       sole clock, rising edge
//   rst       asynchronous active-low reset
//   enable    global step enable; 0 freezes every piece of state
//   r_in      write request / valid tag for d_in
//   d_in      incoming sample
//   rd_en     host read request
//   clr_ovf   clears the overflow flag (a same-cycle drop wins)
//   rd_data   oldest sample, registered, held until the next accepted read
//   rd_valid  one-cycle pulse qualifying a freshly loaded rd_data
//   empty     occupancy == 0
//   full      occupancy == DEPTH
//   count     occupancy
//   overflow  sticky dropped-sample flag
//   chk_sum   modulo-2^N sum of accepted samples since reset
//
// Optional feature
//   FIR_SINK_CHECKSUM_EN  when defined, chk_sum tracks the sum of accepted
//                         samples; otherwise chk_sum is tied to zero and no
//                         accumulator exists.
// ---------------------------------------------------------------------------
module fir_stream_sink #(
  parameter int N     = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     r_in,
  input  logic [N-1:0]             d_in,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [N-1:0]             rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [N-1:0]             chk_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Sample storage: no reset, written only on accepted writes.
  logic [N-1:0]  mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          overflow_reg;
  logic          overflow_next;
  logic [N-1:0]  rd_data_reg;
  logic          rd_valid_reg;

  logic          is_empty;
  logic          is_full;
  logic          rd_accept;
  logic          wr_request;
  logic          wr_accept;
  logic          wr_drop;

  // -------------------------------------------------------------------------
  // Status and handshake qualification
  // -------------------------------------------------------------------------
  assign is_empty   = (count_reg == '0);
  assign is_full    = (count_reg == CW'(DEPTH));

  // A read is only honoured when something is already stored; a write in the
  // same cycle never falls through to the read side.
  assign rd_accept  = enable & rd_en & ~is_empty;
  assign wr_request = enable & r_in;
  // A full buffer still takes a write when a read frees the oldest slot in
  // the same cycle.
  assign wr_accept  = wr_request & (~is_full | rd_accept);
  assign wr_drop    = wr_request & is_full & ~rd_accept;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (wr_accept) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (rd_accept) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    unique case ({wr_accept, rd_accept})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (wr_drop) begin
      overflow_next = 1'b1;
    end else if (enable && clr_ovf) begin
      overflow_next = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Storage write port
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= d_in;
    end
  end

  // -------------------------------------------------------------------------
  // Control state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      // rd_valid is a pure pulse: low whenever no read was accepted,
      // including every cycle with enable low.
      rd_valid_reg <= rd_accept;
      // When full with a simultaneous write the slot being read is the one
      // being overwritten; the nonblocking write means the old sample is read.
      if (rd_accept) begin
        rd_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Optional running checksum
  // -------------------------------------------------------------------------
`ifdef FIR_SINK_CHECKSUM_EN
  logic [N-1:0] sum_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_reg <= '0;
    end else if (wr_accept) begin
      sum_reg <= sum_reg + d_in;
    end
  end

  assign chk_sum = sum_reg;
`else
  assign chk_sum = '0;
`endif

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign empty    = is_empty;
  assign full     = is_full;
  assign count    = count_reg;
  assign overflow = overflow_reg;

endmodule

// File: doc/fir_stream_sink.md
FIR_STREAM_SINK -- requirements
Module: fir_stream_sink

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning buffer depth in samples; power of two, minimum 2.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port enable  input  1  global step enable; 0 freezes all state.
REQ-006 The block SHALL have port r_in  input  1  valid tag for d_in, from the upstream datapath R_OUT.
REQ-007 The block SHALL have port d_in  input  N  sample from the upstream datapath D_OUT.
REQ-008 The block SHALL have port rd_en  input  1  host read request.
REQ-009 The block SHALL have port clr_ovf  input  1  clears the overflow flag.
REQ-010 The block SHALL have port rd_data  output  N  oldest buffered sample, registered.
REQ-011 The block SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-012 The block SHALL have port empty  output  1  count == 0.
REQ-013 The block SHALL have port full  output  1  count == DEPTH.
REQ-014 The block SHALL have port count  output  $clog2(DEPTH)+1  occupancy.
REQ-015 The block SHALL have port overflow  output  1  sticky dropped-sample flag.
REQ-016 The block SHALL have port chk_sum  output  N  running checksum (see Configuration).

Function
REQ-017 On each clk edge with enable=1, the block SHALL treat r_in=1 as a write request; the upstream has no backpressure, so the write is accepted or dropped, never stalled.
REQ-018 The block SHALL store a write in the circular buffer at the write pointer and advance the pointer modulo DEPTH when not full, or when full with an accepted read in the same cycle.
REQ-019 The block SHALL drop a write request made while full without a same-cycle read and set overflow=1 on the next edge.
REQ-020 With rd_en=1, enable=1 and empty=0, the block SHALL load the oldest sample into rd_data, pulse rd_valid=1 on the next cycle, and advance the read pointer modulo DEPTH.
REQ-021 The block SHALL ignore rd_en while empty (rd_valid stays 0), including when a write occurs in the same cycle; there is no fall-through.
REQ-022 The block SHALL leave count unchanged for a simultaneous accepted read and write, increment it for a write only, and decrement it for a read only.
REQ-023 The block SHALL hold rd_data after a read until the next accepted read.
REQ-024 With enable=0, the block SHALL ignore all requests, hold pointers, count, overflow and chk_sum, and drive rd_valid=0.
REQ-025 The block SHALL clear overflow on clr_ovf=1 with enable=1; if a drop occurs in the same cycle, the set wins and overflow=1.

Reset
REQ-026 Assertion of rst=0 SHALL immediately clear pointers, count, overflow, rd_data, rd_valid and chk_sum to 0 and drive empty=1 and full=0, including mid-operation, discarding all buffered samples.
REQ-027 Buffer storage contents SHALL NOT require reset.
REQ-028 The first accepted operation SHALL be on the first rising clk edge after rst returns to 1.

Configuration
REQ-029 With macro FIR_SINK_CHECKSUM_EN defined, chk_sum SHALL equal the modulo-2^N sum of all accepted (not dropped) samples since reset, updated on the accepting edge.
REQ-030 Without FIR_SINK_CHECKSUM_EN, chk_sum SHALL be tied to 0 and no accumulator logic SHALL be present; all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover reset then samples 4,8,12 with r_in=1 -> count=3, empty=0, then three rd_en -> rd_data 4,8,12, each with a one-cycle rd_valid, and empty=1.
REQ-032 The bench SHALL cover 9 consecutive writes (DEPTH=8) of 1..9 -> full=1 after the 8th write, 9 dropped, overflow=1, reads return 1..8.
REQ-033 The bench SHALL cover full buffer with write 0x55 and rd_en in the same cycle -> write accepted, count stays 8, overflow stays 0, last read returns 0x55.
REQ-034 The bench SHALL cover enable=0 with r_in=1 and rd_en=1 for 5 cycles -> count, pointers and chk_sum unchanged, rd_valid=0.
REQ-035 The bench SHALL cover rst=0 pulsed mid-stream with count=5 -> outputs zero asynchronously, empty=1; clr_ovf coincident with a drop -> overflow remains 1.
REQ-036 The bench SHALL cover FIR_SINK_CHECKSUM_EN defined with writes 0xFFFF and 0x0003 -> chk_sum=0x0002; with the macro undefined -> chk_sum=0.
